// File: rtl/mac_tree_loader_if.sv
// mac_tree_loader_if: operand stream, MAC-tree write/select port and result
// stream of the MAC-tree loader, bundled as one interface.
// slave  = the loader's view, master = the surrounding environment's view.
interface mac_tree_loader_if #(
  parameter int I  = 1,
  parameter int J  = 3,
  parameter int W1 = 3,
  parameter int W2 = 7
);
  // operand stream
  logic          op_valid;
  logic          op_ready;
  logic [W1-1:0] op_data;
  logic [I-1:0]  op_tree;

  // MAC-tree write port and selects
  logic [W1-1:0] mac_wr_data;
  logic          mac_a_wren;
  logic          mac_b_wren;
  logic [J-1:0]  mac_sel0;
  logic [I-1:0]  mac_sel1;
  logic [W2-1:0] mac_result;

  // result stream
  logic          res_valid;
  logic          res_ready;
  logic [W2-1:0] res_data;
  logic [I-1:0]  res_tree;
  logic          res_err;

  modport slave (
    input  op_valid, op_data, op_tree, mac_result, res_ready,
    output op_ready, mac_wr_data, mac_a_wren, mac_b_wren, mac_sel0, mac_sel1,
           res_valid, res_data, res_tree, res_err
  );

  modport master (
    output op_valid, op_data, op_tree, mac_result, res_ready,
    input  op_ready, mac_wr_data, mac_a_wren, mac_b_wren, mac_sel0, mac_sel1,
           res_valid, res_data, res_tree, res_err
  );
endinterface

// File: rtl/mac_tree_loader.sv
// mac_tree_loader: streams 2*M operand beats (A lanes then B lanes) into one
// of N MAC trees, waits for the tree to settle, then returns its result on a
// valid/ready stream.
// Optional feature: define MAC_TREE_LOADER_CHECK_EN to build a reference
// dot-product accumulator that flags res_err when the tree result disagrees.
module mac_tree_loader #(
  parameter int I  = 1,
  parameter int J  = 3,
  parameter int W1 = 3,
  parameter int W2 = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_tree_loader_if.slave bus
);
  localparam int           M         = 2 ** J;
  localparam logic [J-1:0] LANE_LAST = J'(M - 1);
  localparam logic [J-1:0] LANE_ZERO = {J{1'b0}};
  localparam logic [J-1:0] LANE_ONE  = J'(1);
  localparam logic [1:0]   WAIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [J-1:0]  lane_cnt_r;
  logic [J-1:0]  lane_next_s;
  logic [1:0]    wait_cnt_r;
  logic [1:0]    wait_next_s;

  logic          accept_s;
  logic          a_phase_s;
  logic          b_phase_s;
  logic          capture_s;
  logic          ready_next_s;

  logic          op_ready_r;
  logic [W1-1:0] mac_wr_data_r;
  logic          mac_a_wren_r;
  logic          mac_b_wren_r;
  logic [J-1:0]  mac_sel0_r;
  logic [I-1:0]  mac_sel1_r;
  logic          res_valid_r;
  logic [W2-1:0] res_data_r;
  logic [I-1:0]  res_tree_r;

  // op_ready is registered, so a beat only transfers once the loader has
  // advertised readiness for a full cycle (never in the first cycle out of reset).
  assign accept_s = bus.op_valid && op_ready_r;

  // Next-state, lane/wait counter and phase decode.
  always_comb begin
    next_state_s = state_r;
    lane_next_s  = lane_cnt_r;
    wait_next_s  = wait_cnt_r;
    a_phase_s    = 1'b0;
    b_phase_s    = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_LOAD_A: begin
        a_phase_s = 1'b1;
        if (accept_s) begin
          if (lane_cnt_r == LANE_LAST) begin
            next_state_s = ST_LOAD_B;
            lane_next_s  = LANE_ZERO;
          end else begin
            next_state_s = ST_LOAD_A;
            lane_next_s  = lane_cnt_r + LANE_ONE;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      ST_LOAD_B: begin
        b_phase_s = 1'b1;
        if (accept_s) begin
          if (lane_cnt_r == LANE_LAST) begin
            next_state_s = ST_WAIT;
            lane_next_s  = LANE_ZERO;
            wait_next_s  = 2'd0;
          end else begin
            lane_next_s  = lane_cnt_r + LANE_ONE;
          end
        end else begin
          next_state_s = ST_LOAD_B;
        end
      end
      ST_WAIT: begin
        // Last B write lands one edge after acceptance; three more edges
        // let the tree settle before the result is sampled.
        if (wait_cnt_r == WAIT_LAST) begin
          capture_s    = 1'b1;
          next_state_s = ST_OUT;
          wait_next_s  = 2'd0;
        end else begin
          wait_next_s  = wait_cnt_r + 2'd1;
        end
      end
      ST_OUT: begin
        if (res_valid_r && bus.res_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_OUT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        lane_next_s  = LANE_ZERO;
        wait_next_s  = 2'd0;
      end
    endcase
    ready_next_s = (next_state_s == ST_IDLE) || (next_state_s == ST_LOAD_A) ||
                   (next_state_s == ST_LOAD_B);
  end

  // State, counters and operand-side readiness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      lane_cnt_r <= LANE_ZERO;
      wait_cnt_r <= 2'd0;
      op_ready_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      lane_cnt_r <= lane_next_s;
      wait_cnt_r <= wait_next_s;
      op_ready_r <= ready_next_s;
    end
  end

  // Registered MAC-tree write port: one strobe per accepted beat, tree select
  // latched from the first A beat and held for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_wr_data_r <= {W1{1'b0}};
      mac_a_wren_r  <= 1'b0;
      mac_b_wren_r  <= 1'b0;
      mac_sel0_r    <= LANE_ZERO;
      mac_sel1_r    <= {I{1'b0}};
    end else begin
      mac_a_wren_r <= accept_s && a_phase_s;
      mac_b_wren_r <= accept_s && b_phase_s;
      if (accept_s) begin
        mac_wr_data_r <= bus.op_data;
        mac_sel0_r    <= lane_cnt_r;
      end else begin
        mac_wr_data_r <= mac_wr_data_r;
        mac_sel0_r    <= mac_sel0_r;
      end
      if (accept_s && (state_r == ST_IDLE)) begin
        mac_sel1_r <= bus.op_tree;
      end else begin
        mac_sel1_r <= mac_sel1_r;
      end
    end
  end

  // Result capture and hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {W2{1'b0}};
      res_tree_r  <= {I{1'b0}};
    end else if (capture_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= bus.mac_result;
      res_tree_r  <= mac_sel1_r;
    end else if (res_valid_r && bus.res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

`ifdef MAC_TREE_LOADER_CHECK_EN
  // Wide enough that acc + a*b never overflows before truncation.
  localparam int PW = 2 * W1 + W2 + 1;

  logic [W1-1:0] a_mem_r [M];
  logic [W2-1:0] acc_r;
  logic          res_err_r;

  // One multiply-accumulate step, wrapping modulo 2**W2 like the tree.
  function automatic logic [W2-1:0] mac_step(input logic [W2-1:0] acc,
                                             input logic [W1-1:0] a,
                                             input logic [W1-1:0] b);
    logic [PW-1:0] sum;
    sum = PW'(acc) + (PW'(a) * PW'(b));
    return sum[W2-1:0];
  endfunction

  // Keep each A operand so it can be paired with the B beat of the same lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < M; l++) a_mem_r[l] <= {W1{1'b0}};
    end else if (accept_s && a_phase_s) begin
      a_mem_r[lane_cnt_r] <= bus.op_data;
    end else begin
      a_mem_r <= a_mem_r;
    end
  end

  // Reference dot product, restarted on the first beat of each transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {W2{1'b0}};
    end else if (accept_s && (state_r == ST_IDLE)) begin
      acc_r <= {W2{1'b0}};
    end else if (accept_s && b_phase_s) begin
      acc_r <= mac_step(acc_r, a_mem_r[lane_cnt_r], bus.op_data);
    end else begin
      acc_r <= acc_r;
    end
  end

  // Mismatch flag rises with res_valid and drops on the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err_r <= 1'b0;
    end else if (capture_s) begin
      res_err_r <= (acc_r != bus.mac_result);
    end else if (res_valid_r && bus.res_ready) begin
      res_err_r <= 1'b0;
    end else begin
      res_err_r <= res_err_r;
    end
  end

  assign bus.res_err = res_err_r;
`else
  assign bus.res_err = 1'b0;
`endif

  assign bus.op_ready    = op_ready_r;
  assign bus.mac_wr_data = mac_wr_data_r;
  assign bus.mac_a_wren  = mac_a_wren_r;
  assign bus.mac_b_wren  = mac_b_wren_r;
  assign bus.mac_sel0    = mac_sel0_r;
  assign bus.mac_sel1    = mac_sel1_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_tree    = res_tree_r;
endmodule

// File: tb/tb_mac_tree_loader.sv
// tb_mac_tree_loader: table-driven bench for mac_tree_loader with a
// behavioural MAC-tree model (per-tree A/B lane memories, result = sum A*B).
module tb_mac_tree_loader;
  localparam int I  = 1;
  localparam int J  = 3;
  localparam int W1 = 3;
  localparam int W2 = 7;
  localparam int N  = 2 ** I;
  localparam int M  = 2 ** J;

  typedef struct {
    logic [I-1:0]    tree;
    logic [M*W1-1:0] a;
    logic [M*W1-1:0] b;
    int              gap;
    int              hold;
    logic [W2-1:0]   exp_data;
    logic            exp_err;
  } vec_t;

  logic clk;
  logic rst_n;
  logic force_zero;
  bit   both_seen;
  int   checks;
  int   errors;

  logic [W1-1:0] mdl_a [N][M];
  logic [W1-1:0] mdl_b [N][M];
  logic [31:0]   mdl_sum;

  mac_tree_loader_if #(.I(I), .J(J), .W1(W1), .W2(W2)) bus ();

  mac_tree_loader #(.I(I), .J(J), .W1(W1), .W2(W2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC-tree model: store lane writes, present the dot product of the selected tree.
  always @(posedge clk) begin
    if (bus.mac_a_wren) mdl_a[bus.mac_sel1][bus.mac_sel0] <= bus.mac_wr_data;
    if (bus.mac_b_wren) mdl_b[bus.mac_sel1][bus.mac_sel0] <= bus.mac_wr_data;
    if (bus.mac_a_wren && bus.mac_b_wren) both_seen <= 1'b1;
  end

  always_comb begin
    mdl_sum = 32'd0;
    for (int l = 0; l < M; l++)
      mdl_sum = mdl_sum + (32'(mdl_a[bus.mac_sel1][l]) * 32'(mdl_b[bus.mac_sel1][l]));
    bus.mac_result = force_zero ? {W2{1'b0}} : mdl_sum[W2-1:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_bus();
    return 32'({bus.op_ready, bus.mac_wr_data, bus.mac_a_wren, bus.mac_b_wren,
                bus.mac_sel0, bus.mac_sel1, bus.res_valid, bus.res_data,
                bus.res_tree, bus.res_err});
  endfunction

  // mode 0: every lane v; mode 1: lane j = j; mode 2: lane j = M-1-j
  function automatic logic [M*W1-1:0] fill(input int mode, input int v);
    logic [M*W1-1:0] r;
    r = {(M*W1){1'b0}};
    for (int j = 0; j < M; j++)
      r[j*W1 +: W1] = (mode == 0) ? W1'(v) : (mode == 1) ? W1'(j) : W1'(M - 1 - j);
    return r;
  endfunction

  // Present one beat and wait (bounded) for it to be taken; returns at edge+1.
  task automatic send_beat(input logic [W1-1:0] d, input logic [I-1:0] t, output bit acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_data  = d;
    bus.op_tree  = t;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = bus.op_ready;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    bit            acc, ok_acc, ok_wr, ok_lat, ok_hold;
    logic [W1-1:0] d;
    ok_acc = 1'b1; ok_wr = 1'b1; ok_lat = 1'b1; ok_hold = 1'b1;
    for (int k = 0; k < 2 * M; k++) begin
      d = (k < M) ? v.a[(k % M)*W1 +: W1] : v.b[(k % M)*W1 +: W1];
      // op_tree only matters on the first beat; scramble it afterwards
      send_beat(d, (k == 0) ? v.tree : ~v.tree, acc);
      ok_acc &= acc;
      if (bus.mac_a_wren !== (k < M) || bus.mac_b_wren !== (k >= M) ||
          bus.mac_sel0 !== J'(k % M) || bus.mac_wr_data !== d || bus.mac_sel1 !== v.tree)
        ok_wr = 1'b0;
      if (k < 2 * M - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          @(posedge clk); #1;
          if (bus.mac_a_wren || bus.mac_b_wren) ok_wr = 1'b0;
        end
      end
    end
    check({tag, "_accept"}, 32'(ok_acc), 32'd1);
    check({tag, "_wr_port"}, 32'(ok_wr), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b0) ok_lat = 1'b0;
    end
    @(posedge clk); #1;
    if (bus.res_valid !== 1'b1) ok_lat = 1'b0;
    check({tag, "_latency"}, 32'(ok_lat), 32'd1);
    check({tag, "_res_data"}, 32'(bus.res_data), 32'(v.exp_data));
    check({tag, "_res_tree"}, 32'(bus.res_tree), 32'(v.tree));
    check({tag, "_res_err"}, 32'(bus.res_err), 32'(v.exp_err));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.res_data !== v.exp_data || bus.op_ready !== 1'b0 ||
          bus.mac_sel1 !== v.tree)
        ok_hold = 1'b0;
    end
    check({tag, "_hold"}, 32'(ok_hold), 32'd1);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    // after handshake: res_valid=0, op_ready=1, res_err cleared
    check({tag, "_handshake"}, 32'({bus.res_valid, bus.op_ready, bus.res_err}), 32'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [4];
    bit   acc;
    checks = 0; errors = 0; both_seen = 1'b0; force_zero = 1'b0;
    bus.op_valid = 1'b0; bus.op_data = {W1{1'b0}}; bus.op_tree = {I{1'b0}};
    bus.res_ready = 1'b0;

    tbl[0] = '{tree: 1'b0, a: fill(0, 1), b: fill(0, 1), gap: 0, hold: 0, exp_data: 7'd8,  exp_err: 1'b0};
    tbl[1] = '{tree: 1'b1, a: fill(1, 0), b: fill(0, 1), gap: 1, hold: 5, exp_data: 7'd28, exp_err: 1'b0};
    tbl[2] = '{tree: 1'b0, a: fill(0, 7), b: fill(0, 7), gap: 0, hold: 1, exp_data: 7'd8,  exp_err: 1'b0};
    tbl[3] = '{tree: 1'b1, a: fill(1, 0), b: fill(2, 0), gap: 2, hold: 2, exp_data: 7'd56, exp_err: 1'b0};

    // power-on reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", out_bus(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(bus.op_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(bus.op_ready), 32'd1);

    for (int t = 0; t < 4; t++) run_txn($sformatf("vec%0d", t), tbl[t]);

    // reset after 5 beats of a tree-1 transaction
    for (int k = 0; k < 5; k++) send_beat(3'd5, 1'b1, acc);
    check("mid_sel1_before_rst", 32'(bus.mac_sel1), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid_reset_outputs", out_bus(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_ready_after_edge", 32'(bus.op_ready), 32'd1);
    begin
      vec_t fresh;
      fresh = '{tree: 1'b1, a: fill(0, 2), b: fill(0, 3), gap: 1, hold: 0, exp_data: 7'd48, exp_err: 1'b0};
      run_txn("fresh", fresh);
    end

`ifdef MAC_TREE_LOADER_CHECK_EN
    begin
      vec_t bad;
      force_zero = 1'b1;
      bad = '{tree: 1'b0, a: fill(0, 1), b: fill(0, 1), gap: 0, hold: 1, exp_data: 7'd0, exp_err: 1'b1};
      run_txn("chk", bad);
      force_zero = 1'b0;
    end
`endif

    check("never_both_wren", 32'(both_seen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
